// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// State encodings, register-zero constant and the control bundle.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [3:0] REG_ZERO = 4'h0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush,
// D-mem freeze with watchdog, and HLT drain-then-halt.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [3:0]       ID_EX_RegisterRd,
  input  logic [3:0]       IF_ID_RegisterRs,
  input  logic [3:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_Halt,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt, wait_n;
  logic [1:0] drain_cnt, drain_n;
  logic       timeout_n;
  logic       load_use;
  logic       run_like;
  ctrl_t      ctrl;

  assign load_use = ID_EX_MemRead
    && (ID_EX_RegisterRd != REG_ZERO)
    && ((IF_ID_RegisterRs == ID_EX_RegisterRd)
     || (IF_ID_UsesRt
      && (IF_ID_RegisterRt == ID_EX_RegisterRd)));

  // A MEM_WAIT cycle with busy released behaves exactly like RUN
  assign run_like = (state == ST_RUN)
    || ((state == ST_MEM_WAIT) && !dmem_busy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      drain_cnt   <= drain_n;
      mem_timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    drain_n   = drain_cnt;
    timeout_n = mem_timeout;
    if (run_like) begin
      state_n = ST_RUN;
      if (dmem_busy) begin
        state_n = ST_MEM_WAIT;
        wait_n  = 8'd1;
      end else if (!branch_taken && !load_use
                   && IF_ID_Halt) begin
        state_n = ST_DRAIN;
        drain_n = DRAIN_INIT;
      end
    end else begin
      unique case (state)
        ST_MEM_WAIT: begin
          if (wait_cnt == TIMEOUT) begin
            timeout_n = 1'b1;
            state_n   = ST_HALTED;
          end else begin
            wait_n = wait_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (dmem_busy)
            drain_n = drain_cnt;
          else if (branch_taken)
            state_n = ST_RUN;
          else if (drain_cnt == 2'd0)
            state_n = ST_HALTED;
          else
            drain_n = drain_cnt - 2'd1;
        end
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (!rst_n) begin
      ctrl = CTRL_FREEZE;
    end else if (run_like) begin
      if (dmem_busy)         ctrl = CTRL_FREEZE;
      else if (branch_taken) ctrl = CTRL_FLUSH;
      else if (load_use)     ctrl = CTRL_BUBBLE;
      else if (IF_ID_Halt)   ctrl = CTRL_HOLD;
      else                   ctrl = CTRL_PASS;
    end else begin
      unique case (state)
        ST_DRAIN: begin
          if (dmem_busy)         ctrl = CTRL_FREEZE;
          else if (branch_taken) ctrl = CTRL_FLUSH;
          else                   ctrl = CTRL_BUBBLE;
        end
        default: ctrl = CTRL_FREEZE;
      endcase
    end
  end

  assign PC_Write    = ctrl.pc_write;
  assign IF_ID_Write = ctrl.if_id_write;
  assign IF_ID_Flush = ctrl.if_id_flush;
  assign ID_EX_Flush = ctrl.id_ex_flush;
  assign pipe_freeze = ctrl.pipe_freeze;
  assign halted      = (state == ST_HALTED);

  logic stall_inc, flush_inc;

  assign stall_inc = rst_n && !PC_Write
    && (state != ST_HALTED);
  assign flush_inc = rst_n && IF_ID_Flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios, random
// traffic and counter saturation against a behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int DC = 3;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ID_EX_MemRead;
  logic [3:0]   ID_EX_RegisterRd;
  logic [3:0]   IF_ID_RegisterRs;
  logic [3:0]   IF_ID_RegisterRt;
  logic         IF_ID_UsesRt;
  logic         IF_ID_Halt;
  logic         branch_taken;
  logic         dmem_busy;
  logic         PC_Write, IF_ID_Write, IF_ID_Flush;
  logic         ID_EX_Flush, pipe_freeze;
  logic         halted, mem_timeout;
  logic [W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(
    .DRAIN_CYCLES (DC),
    .MEM_TIMEOUT  (TO),
    .CNT_W        (W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRd (ID_EX_RegisterRd),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .IF_ID_UsesRt     (IF_ID_UsesRt),
    .IF_ID_Halt       (IF_ID_Halt),
    .branch_taken     (branch_taken),
    .dmem_busy        (dmem_busy),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .pipe_freeze      (pipe_freeze),
    .halted           (halted),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: behaviour tracked as flags and counts, not as a state code
  bit m_halted, m_timeout, m_draining;
  int m_drain_left, m_busy_run;
  int m_stall, m_flush;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_timeout = 0; m_draining = 0;
    m_drain_left = 0; m_busy_run = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input bit r, input bit mr,
                      input int rd, input int rs,
                      input int rt, input bit ut,
                      input bit h, input bit br,
                      input bit bz);
    bit lu;
    bit e_pc, e_ifw, e_iff, e_exf, e_frz;
    @(negedge clk);
    rst_n = r; ID_EX_MemRead = mr;
    ID_EX_RegisterRd = 4'(rd);
    IF_ID_RegisterRs = 4'(rs);
    IF_ID_RegisterRt = 4'(rt);
    IF_ID_UsesRt = ut; IF_ID_Halt = h;
    branch_taken = br; dmem_busy = bz;
    #1;
    lu = mr && rd != 0 && (rs == rd || (ut && rt == rd));
    {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b00001;
    if (r && !m_halted) begin
      if (bz)      {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b00001;
      else if (br) {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b11110;
      else if (m_draining || lu)
                   {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b00010;
      else if (h)  {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b00000;
      else         {e_pc, e_ifw, e_iff, e_exf, e_frz} = 5'b11000;
    end
    chk("pc_write", PC_Write, e_pc);
    chk("if_id_write", IF_ID_Write, e_ifw);
    chk("if_id_flush", IF_ID_Flush, e_iff);
    chk("id_ex_flush", ID_EX_Flush, e_exf);
    chk("pipe_freeze", pipe_freeze, e_frz);
    chk("halted", halted, m_halted);
    chk("mem_timeout", mem_timeout, m_timeout);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (!m_halted) begin
      if (!e_pc && m_stall < 65535) m_stall++;
      if (e_iff && m_flush < 65535) m_flush++;
      if (m_draining) begin
        if (bz) begin
        end else if (br) begin
          m_draining = 0;
        end else if (m_drain_left == 1) begin
          m_draining = 0; m_halted = 1;
        end else begin
          m_drain_left--;
        end
      end else if (bz) begin
        m_busy_run++;
        if (m_busy_run == TO + 1) begin
          m_timeout = 1; m_halted = 1;
        end
      end else begin
        m_busy_run = 0;
        if (!br && !lu && h) begin
          m_draining = 1; m_drain_left = DC;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 1, 2, 1, 0, 0, 0);
  endtask

  task automatic rst();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst(); rst();
    idle(1);
    // load-use on Rs
    step(1, 1, 3, 3, 5, 1, 0, 0, 0);
    #2 chk("t1_stall", stall_cycles, 1);
    step(1, 1, 3, 1, 3, 1, 0, 0, 0);
    step(1, 1, 3, 1, 3, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 3, 3, 3, 1, 0, 1, 0);
    #2 chk("t2_flush", flush_count, 1);
    chk("t2_stall", stall_cycles, 2);
    // D-mem busy for four cycles
    rst();
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 2, 1, 0, 0, 1);
    idle(1);
    #2 chk("t3_stall", stall_cycles, 4);
    // HLT drains then halts
    rst();
    step(1, 0, 0, 1, 2, 1, 1, 0, 0);
    idle(3);
    #2 chk("t4_halted", halted, 1);
    idle(2);
    #2 chk("t4_sticky", halted, 1);
    chk("t4_stall", stall_cycles, 4);
    // branch in second drain cycle cancels HLT
    rst();
    step(1, 0, 0, 1, 2, 1, 1, 0, 0);
    idle(1);
    step(1, 0, 0, 1, 2, 1, 0, 1, 0);
    idle(3);
    #2 chk("t4_cancel", halted, 0);
    // watchdog
    rst();
    for (int i = 0; i < TO + 1; i++)
      step(1, 0, 0, 1, 2, 1, 0, 0, 1);
    #2 chk("t5_timeout", mem_timeout, 1);
    chk("t5_halted", halted, 1);
    rst();
    #2 chk("t6_halt_rst", halted, 0);
    step(1, 0, 0, 1, 2, 1, 0, 0, 1);
    step(1, 0, 0, 1, 2, 1, 0, 0, 1);
    rst();
    #2 chk("t6_stall_rst", stall_cycles, 0);
    idle(1);
    // random traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(199) != 0,
           $urandom_range(2) == 0,
           $urandom_range(3), $urandom_range(3),
           $urandom_range(3), $urandom_range(1) == 1,
           $urandom_range(19) == 0,
           $urandom_range(5) == 0,
           $urandom_range(7) == 0);
    // flush counter saturation
    rst();
    for (int i = 0; i < 65540; i++)
      step(1, 0, 0, 1, 2, 1, 0, 1, 0);
    #2 chk("t6_flush_sat", flush_count, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
